au_seq_ctrl: RTL and testbench

Multi-nibble arithmetic sequencer for the 4-bit arithmetic unit (AU).
- Accepts a wide add or subtract request and issues one AU operation per cycle, least-significant nibble first.
- Chains the carry/borrow between nibbles and assembles the wide result, carry-out and zero flag.
- Sits between the host datapath and a single AU instance; the parent module instantiates both.

---
 rtl/au_pkg.sv | 17 +
 rtl/au_seq_ctrl_if.sv | 22 ++
 rtl/au_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_au_seq_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/au_pkg.sv
// Shared definitions for the 4-bit arithmetic unit and its multi-nibble sequencer:
// AU operation codes and the sequencer state encoding.
package au_pkg;

    localparam logic [2:0] NOP  = 3'd0;
    localparam logic [2:0] ADD  = 3'd1;
    localparam logic [2:0] SUB  = 3'd2;
    localparam logic [2:0] ADDC = 3'd5;
    localparam logic [2:0] SUBC = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/au_seq_ctrl_if.sv
// Bus between the sequencer (master) and the single combinational 4-bit AU (slave).
interface au_seq_ctrl_if;

    logic [2:0] au_sel;
    logic [3:0] au_a;
    logic [3:0] au_b;
    logic       au_cin;
    logic [3:0] au_out;
    logic       au_cout;
    logic       au_z;

    modport master (
        output au_sel, au_a, au_b, au_cin,
        input  au_out, au_cout, au_z
    );

    modport slave (
        input  au_sel, au_a, au_b, au_cin,
        output au_out, au_cout, au_z
    );

endinterface

// File: rtl/au_seq_ctrl.sv
// Wide add/subtract sequencer: one AU operation per cycle, LS nibble first, carry chained.
// Optional signed-overflow flag is built when AU_SEQ_OVF_EN is defined; otherwise ovf is tied 0.
module au_seq_ctrl
    import au_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   op,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   zero,
    output logic                   ovf,
    au_seq_ctrl_if.master          au
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);

    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              zacc_q, zacc_d;
    logic              zero_q, zero_d;
    logic [W-1:0]      result_q, result_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic              op_q, op_d;
    logic              last_nib;
`ifdef AU_SEQ_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        zacc_d     = zacc_q;
        zero_d     = zero_q;
        result_d   = result_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
`ifdef AU_SEQ_OVF_EN
        ovf_d      = ovf_q;
`endif
        au.au_sel  = NOP;
        au.au_a    = 4'd0;
        au.au_b    = 4'd0;
        au.au_cin  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    zacc_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                au.au_a   = a_q[{idx_q, 2'b00} +: 4];
                au.au_b   = b_q[{idx_q, 2'b00} +: 4];
                au.au_cin = carry_q;
                if (idx_q == '0) au.au_sel = op_q ? SUB : ADD;
                else             au.au_sel = op_q ? SUBC : ADDC;

                result_d[{idx_q, 2'b00} +: 4] = au.au_out;
                carry_d = au.au_cout;
                zacc_d  = zacc_q & au.au_z;

                if (last_nib) begin
                    zero_d  = zacc_q & au.au_z;
`ifdef AU_SEQ_OVF_EN
                    // Carry into MSB from the bit identity a^b'^r; carry out of MSB is the inverted borrow on subtract.
                    ovf_d   = (a_q[W-1] ^ (b_q[W-1] ^ op_q) ^ au.au_out[3])
                            ^ (au.au_cout ^ op_q);
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            zacc_q   <= zacc_d;
            zero_q   <= zero_d;
            result_q <= result_d;
        end
    end

    // Operand latches only matter while RUN, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
    end

`ifdef AU_SEQ_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = carry_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_au_seq_ctrl.sv
// Directed bench for au_seq_ctrl with a behavioural 4-bit AU on the bus.
module tb_au_seq_ctrl;
    import au_pkg::*;

    localparam int NIB = 4;
`ifdef AU_SEQ_OVF_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          op;
    logic [15:0]   a;
    logic [15:0]   b;
    logic          busy;
    logic          done;
    logic [15:0]   result;
    logic          cout;
    logic          zero;
    logic          ovf;
    logic [4:0]    au_sum;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    int ndone;

    au_seq_ctrl_if bus ();

    au_seq_ctrl #(.NIBBLES(NIB)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero),
        .ovf    (ovf),
        .au     (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        au_sum = 5'd0;
        case (bus.au_sel)
            ADD:     au_sum = {1'b0, bus.au_a} + {1'b0, bus.au_b};
            SUB:     au_sum = {1'b0, bus.au_a} - {1'b0, bus.au_b};
            ADDC:    au_sum = {1'b0, bus.au_a} + {1'b0, bus.au_b} + {4'd0, bus.au_cin};
            SUBC:    au_sum = {1'b0, bus.au_a} - {1'b0, bus.au_b} - {4'd0, bus.au_cin};
            default: au_sum = 5'd0;
        endcase
        bus.au_out  = au_sum[3:0];
        bus.au_cout = au_sum[4];
        bus.au_z    = (au_sum[3:0] == 4'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, then wait (bounded) for done; lat is the cycle done appeared in.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic top);
        a = ta; b = tb_; op = top; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        tick(); tick();
        chk("rst_busy",   busy,        0);
        chk("rst_done",   done,        0);
        chk("rst_result", result,      0);
        chk("rst_cout",   cout,        0);
        chk("rst_zero",   zero,        0);
        chk("rst_ovf",    ovf,         0);
        chk("rst_au_sel", bus.au_sel,  NOP);
        chk("rst_au_a",   bus.au_a,    0);
        chk("rst_au_cin", bus.au_cin,  0);
        rst = 1'b0;
        tick();

        // Add without carry-out, with early-cycle bus inspection
        a = 16'h1234; b = 16'h0FCD; op = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("add_c1_busy",   busy,       1);
        chk("add_c1_sel",    bus.au_sel, ADD);
        chk("add_c1_a",      bus.au_a,   4'h4);
        chk("add_c1_b",      bus.au_b,   4'hD);
        tick();
        chk("add_c2_sel",    bus.au_sel, ADDC);
        chk("add_c2_cin",    bus.au_cin, 1);
        chk("add_c2_a",      bus.au_a,   4'h3);
        lat = 2;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        chk("add_latency", lat,    5);
        chk("add_result",  result, 16'h2201);
        chk("add_cout",    cout,   0);
        chk("add_zero",    zero,   0);
        chk("add_busy",    busy,   1);
        tick();
        chk("add_done_pulse", done, 0);
        chk("add_idle_busy",  busy, 0);
        chk("add_hold",       result, 16'h2201);

        run_op(16'hFFFF, 16'h0001, 1'b0);
        chk("wrap_latency", lat,    5);
        chk("wrap_result",  result, 16'h0000);
        chk("wrap_cout",    cout,   1);
        chk("wrap_zero",    zero,   1);
        tick();

        run_op(16'h1000, 16'h0001, 1'b1);
        chk("sub1_result", result, 16'h0FFF);
        chk("sub1_cout",   cout,   0);
        chk("sub1_zero",   zero,   0);
        tick();

        run_op(16'h0005, 16'h0007, 1'b1);
        chk("sub2_result", result, 16'hFFFE);
        chk("sub2_cout",   cout,   1);
        tick();

        run_op(16'h7FFF, 16'h0001, 1'b0);
        chk("ovf_add_result", result, 16'h8000);
        chk("ovf_add",        ovf,    EXP_OVF);
        tick();

        run_op(16'h8000, 16'h0001, 1'b1);
        chk("ovf_sub_result", result, 16'h7FFF);
        chk("ovf_sub_cout",   cout,   0);
        chk("ovf_sub",        ovf,    EXP_OVF);
        tick();

        // Start pulses while busy must be ignored
        a = 16'h0100; b = 16'h0200; op = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) tick();
            if (done) ndone++;
            if (c == 2) chk("busy_c2", busy, 1);
            if (c == 2 || c == 5) begin
                start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; op = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk("ign_ndone",  ndone,  1);
        chk("ign_result", result, 16'h0300);
        chk("ign_busy",   busy,   0);

        // Reset in the middle of RUN drops the request
        run_op(16'h1111, 16'h1111, 1'b0);
        tick();
        a = 16'hFFFF; b = 16'h0001; op = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy",   busy,   0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_cout",   cout,   0);
        chk("mid_rst_zero",   zero,   0);
        chk("mid_rst_ovf",    ovf,    0);
        chk("mid_rst_au_sel", bus.au_sel, NOP);
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) ndone++;
            tick();
        end
        chk("mid_rst_nodone", ndone, 0);

        run_op(16'h0F0F, 16'h00F1, 1'b0);
        chk("post_rst_latency", lat,    5);
        chk("post_rst_result",  result, 16'h1000);
        chk("post_rst_cout",    cout,   0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
